// File: rtl/ecdsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecdsa_pkg
//  Description : Shared constants for the ECDSA datapath: operand width,
//                multiplier-arbiter state encoding and requester indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecdsa_pkg;

    localparam int WIDTH = 381;

    // Multiplier arbiter states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Requester slots on the shared multiplier
    localparam int REQ_TOP   = 0;
    localparam int REQ_ECADD = 1;
    localparam int REQ_ECDBL = 2;

endpackage
`default_nettype wire

// File: rtl/mont_mult_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. The winner is the first
//                set request bit scanning upward from last_grant+1, mod NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last_grant,
    output logic [NREQ-1:0] grant_oh,
    output logic [2:0]      grant_idx,
    output logic            any
);

    int w_dist;
    int w_best_idx;
    int w_best_dist;

    // Winner is the requesting slot with the smallest rotational distance past last_grant
    always_comb begin
        w_dist      = 0;
        w_best_idx  = 0;
        w_best_dist = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(last_grant)) % NREQ;
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_idx  = i;
            end
        end
    end

    // One-hot form of the winner; all zero when nothing is requesting
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = req[i] && (i == w_best_idx);
        end
    end

    assign grant_idx = w_best_idx[2:0];
    assign any       = |req;

endmodule
`default_nettype wire

// File: rtl/mont_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mont_mult_arbiter
//  Description : Shares one Montgomery multiplier between NREQ requesters.
//                Round-robin grant, operand latch, start/done handshake,
//                one-cycle response pulse and a watchdog against a hung
//                multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module mont_mult_arbiter #(
    parameter int NREQ    = 3,
    parameter int WIDTH   = ecdsa_pkg::WIDTH,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0]      in_m,
    output logic [NREQ-1:0]       rsp_done,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  mm_start,
    output logic [WIDTH-1:0]      mm_a,
    output logic [WIDTH-1:0]      mm_b,
    output logic [WIDTH-1:0]      mm_m,
    input  logic                  mm_done,
    input  logic [WIDTH-1:0]      mm_result,
    output logic                  busy,
    output logic [2:0]            grant_idx,
    output logic [31:0]           op_count,
    output logic                  timeout_err
);
    import ecdsa_pkg::*;

    // Watchdog only needs to count up to TIMEOUT-1
    localparam int               C_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               C_WD_EN   = (TIMEOUT != 0);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [2:0]        r_last_grant;
    logic [C_WD_W-1:0] r_wd;
    logic [NREQ-1:0]   r_grant_oh;
    logic [NREQ-1:0]   w_pick_oh;
    logic [2:0]        w_pick_idx;
    logic              w_pick_any;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic              w_expire;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant_oh   (w_pick_oh),
        .grant_idx  (w_pick_idx),
        .any        (w_pick_any)
    );

    assign w_expire = C_WD_EN && (r_wd == C_WD_LAST);

    // Select the winning requester's operands
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_oh[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a done coincident with watchdog expiry is a normal completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_any) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (mm_done || w_expire) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Registered outputs: operand latch, start/done pulses, watchdog and counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mm_start     <= 1'b0;
            mm_a         <= '0;
            mm_b         <= '0;
            mm_m         <= '0;
            rsp_done     <= '0;
            rsp_err      <= 1'b0;
            rsp_result   <= '0;
            busy         <= 1'b0;
            grant_idx    <= '0;
            op_count     <= '0;
            timeout_err  <= 1'b0;
            r_last_grant <= 3'(NREQ - 1);
            r_wd         <= '0;
            r_grant_oh   <= '0;
        end else begin
            mm_start <= 1'b0;
            rsp_done <= '0;
            busy     <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        mm_a       <= w_sel_a;
                        mm_b       <= w_sel_b;
                        mm_m       <= in_m;
                        grant_idx  <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        mm_start   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_wd <= '0;
                end
                ST_WAIT: begin
                    if (mm_done) begin
                        rsp_result <= mm_result;
                        rsp_err    <= 1'b0;
                        rsp_done   <= r_grant_oh;
                    end else if (w_expire) begin
                        rsp_result  <= '0;
                        rsp_err     <= 1'b1;
                        timeout_err <= 1'b1;
                        rsp_done    <= r_grant_oh;
                    end else begin
                        r_wd <= r_wd + C_WD_W'(1);
                    end
                end
                ST_RESP: begin
                    r_last_grant <= grant_idx;
                    if (!rsp_err) begin
                        op_count <= op_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mont_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mont_mult_arbiter
//  Description : Self-checking bench for mont_mult_arbiter with a stub
//                multiplier (a*b after a programmable latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_mult_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 381;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      in_m;
    logic [NREQ-1:0]   rsp_done;
    logic              rsp_err;
    logic [W-1:0]      rsp_result;
    logic              mm_start;
    logic [W-1:0]      mm_a;
    logic [W-1:0]      mm_b;
    logic [W-1:0]      mm_m;
    logic              mm_done;
    logic [W-1:0]      mm_result;
    logic              busy;
    logic [2:0]        grant_idx;
    logic [31:0]       op_count;
    logic              timeout_err;

    // stub multiplier controls
    int           stub_lat;
    bit           stub_hang;
    bit           stub_fixed_en;
    logic [W-1:0] stub_fixed;
    logic         stub_done;
    logic [W-1:0] stub_res;
    logic         stub_pend;
    int           stub_cnt;
    logic         inj_done;
    logic [W-1:0] inj_res;

    int total = 0;
    int bad   = 0;
    int nstart = 0;

    always #5 clk = ~clk;

    assign mm_done   = stub_done | inj_done;
    assign mm_result = inj_done ? inj_res : stub_res;

    mont_mult_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .in_m        (in_m),
        .rsp_done    (rsp_done),
        .rsp_err     (rsp_err),
        .rsp_result  (rsp_result),
        .mm_start    (mm_start),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_m        (mm_m),
        .mm_done     (mm_done),
        .mm_result   (mm_result),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .op_count    (op_count),
        .timeout_err (timeout_err)
    );

    // Stub multiplier: done pulse stub_lat cycles after the mm_start cycle
    always @(posedge clk) begin
        if (!resetn) begin
            stub_pend <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
        end else begin
            stub_done <= 1'b0;
            if (mm_start) begin
                stub_pend <= !stub_hang;
                stub_cnt  <= 1;
            end else if (stub_pend) begin
                if (stub_cnt == stub_lat - 1) begin
                    stub_done <= 1'b1;
                    stub_res  <= stub_fixed_en ? stub_fixed : mm_a * mm_b;
                    stub_pend <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    // Count start pulses to detect overlapping issues
    always @(negedge clk) begin
        if (mm_start) nstart++;
    end

    typedef struct {
        bit           rst_first;
        logic [2:0]   mask;
        bit           keep;
        int           exp_idx;
        logic [W-1:0] exp_res;
    } vec_t;

    localparam int NVEC = 8;
    vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_done == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_done == '0) chk("rsp_done_timeout", 1, 0);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!mm_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mm_start) chk("mm_start_timeout", 1, 0);
    endtask

    initial begin
        int         n;
        int         base;
        int         ops;
        bit         last;
        logic [2:0] exp_oh;

        resetn        = 1'b0;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        in_m          = '0;
        inj_done      = 1'b0;
        inj_res       = '0;
        stub_lat      = 10;
        stub_hang     = 1'b0;
        stub_fixed_en = 1'b1;
        stub_fixed    = 42;
        base          = 0;
        ops           = 0;

        // grant order tables: {reset first, initial mask, keep winner requesting, winner, a*b}
        tbl[0] = '{1'b1, 3'b111, 1'b0, 0, 15};
        tbl[1] = '{1'b0, 3'b000, 1'b0, 1, 77};
        tbl[2] = '{1'b0, 3'b000, 1'b0, 2, 221};
        tbl[3] = '{1'b1, 3'b111, 1'b0, 0, 15};
        tbl[4] = '{1'b0, 3'b000, 1'b1, 1, 77};
        tbl[5] = '{1'b0, 3'b000, 1'b0, 2, 221};
        tbl[6] = '{1'b0, 3'b000, 1'b1, 1, 77};
        tbl[7] = '{1'b0, 3'b000, 1'b1, 1, 77};

        // ---------------- reset state
        do_reset();
        chk("rst_rsp_done", rsp_done, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_m", mm_m, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // ---------------- single request on requester 0
        set_ops(0, 3, 5);
        in_m      = 7;
        req_valid = 3'b001;
        @(negedge clk);           // IDLE cycle was the first, start shows in the second
        chk("t1_mm_start", mm_start, 1);
        chk("t1_mm_a", mm_a, 3);
        chk("t1_mm_b", mm_b, 5);
        chk("t1_mm_m", mm_m, 7);
        chk("t1_grant", grant_idx, 0);
        chk("t1_busy", busy, 1);
        wait_rsp(n);
        chk("t1_latency", n, 11);
        chk("t1_rsp_done", rsp_done, 3'b001);
        chk("t1_result", rsp_result, 42);
        chk("t1_err", rsp_err, 0);
        @(negedge clk);
        req_valid = '0;
        chk("t1_done_cleared", rsp_done, 0);
        chk("t1_op_count", op_count, 1);
        chk("t1_idle", busy, 0);

        // ---------------- table-driven rotation scenarios
        stub_fixed_en = 1'b0;
        stub_lat      = 4;
        set_ops(0, 3, 5);
        set_ops(1, 7, 11);
        set_ops(2, 13, 17);
        for (int k = 0; k < NVEC; k++) begin
            if (tbl[k].rst_first) begin
                do_reset();
                base      = nstart;
                ops       = 0;
                req_valid = tbl[k].mask;
            end
            wait_rsp(n);
            ops++;
            exp_oh = '0;
            exp_oh[tbl[k].exp_idx] = 1'b1;
            chk("tbl_rsp_done", rsp_done, exp_oh);
            chk("tbl_grant", grant_idx, tbl[k].exp_idx);
            chk("tbl_result", rsp_result, tbl[k].exp_res);
            chk("tbl_err", rsp_err, 0);
            chk("tbl_start_count", nstart - base, ops);
            @(negedge clk);
            if (k == NVEC - 1) last = 1'b1;
            else               last = tbl[k + 1].rst_first;
            if (last)               req_valid = '0;
            else if (!tbl[k].keep)  req_valid[tbl[k].exp_idx] = 1'b0;
        end
        chk("tbl_op_count", op_count, 5);

        // ---------------- watchdog abort
        stub_hang = 1'b1;
        do_reset();
        req_valid = 3'b010;
        wait_start(n);
        chk("to_start_lat", n, 1);
        chk("to_grant", grant_idx, 1);
        wait_rsp(n);
        chk("to_latency", n, 17);
        chk("to_rsp_done", rsp_done, 3'b010);
        chk("to_err", rsp_err, 1);
        chk("to_result", rsp_result, 0);
        chk("to_flag", timeout_err, 1);
        @(negedge clk);
        req_valid = '0;
        chk("to_op_count", op_count, 0);
        chk("to_flag_sticky", timeout_err, 1);

        // ---------------- mm_done while IDLE is ignored
        inj_res  = 77;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("idle_done_rsp", rsp_done, 0);
        chk("idle_done_busy", busy, 0);
        @(negedge clk);
        chk("idle_done_rsp2", rsp_done, 0);

        // ---------------- mm_done coincident with watchdog expiry
        req_valid = 3'b001;
        wait_start(n);
        repeat (16) @(negedge clk);
        inj_res  = 99;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("coinc_rsp_done", rsp_done, 3'b001);
        chk("coinc_err", rsp_err, 0);
        chk("coinc_result", rsp_result, 99);
        chk("coinc_flag_sticky", timeout_err, 1);
        @(negedge clk);
        req_valid = '0;
        chk("coinc_op_count", op_count, 1);

        // ---------------- reset during WAIT
        stub_hang = 1'b0;
        stub_lat  = 10;
        req_valid = 3'b111;
        wait_start(n);
        chk("rw_grant_before", grant_idx, 1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rw_busy", busy, 0);
        chk("rw_rsp_done", rsp_done, 0);
        chk("rw_mm_start", mm_start, 0);
        chk("rw_op_count", op_count, 0);
        chk("rw_timeout_err", timeout_err, 0);
        @(negedge clk);
        chk("rw_regrant_start", mm_start, 1);
        chk("rw_regrant_idx", grant_idx, 0);
        chk("rw_regrant_a", mm_a, 3);
        wait_rsp(n);
        chk("rw_rsp_done2", rsp_done, 3'b001);
        chk("rw_result", rsp_result, 15);
        @(negedge clk);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
